// File: rtl/exu_bru_pred.sv
// Execute-stage branch resolution unit: resolves branches/jumps/fences, issues registered redirects,
// squashes wrong-path requests, counts branches/mispredicts. Optional BHT built when BRU_BHT_EN is defined.
module exu_bru_pred #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           inst_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic [ADDR_WIDTH-1:0] op1_jump_i,
    input  logic [ADDR_WIDTH-1:0] op2_jump_i,
    input  logic                  pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] pred_addr_i,
    input  logic                  int_assert_i,
    input  logic [ADDR_WIDTH-1:0] int_addr_i,
    output logic                  jump_flag_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
    output logic                  lookup_taken_o,
    output logic [CNT_WIDTH-1:0]  br_cnt_o,
    output logic [CNT_WIDTH-1:0]  mispred_cnt_o
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int IW = $clog2(BHT_DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
    logic                  redirect_d;
    logic [ADDR_WIDTH-1:0] redirect_addr_d;
    logic                  br_resolved;
    logic                  mispred;
    logic                  actual_taken;
    logic                  funct3_valid;
    logic [ADDR_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0]  br_cnt_q, mispred_cnt_q;
    logic                  unused_inst;

    assign req_ready_o   = 1'b1;
    assign target        = op1_jump_i + op2_jump_i;
    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
    assign unused_inst   = ^{inst_i[31:15], inst_i[11:7]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        actual_taken = 1'b0;
        funct3_valid = 1'b1;
        case (inst_i[14:12])
            3'b000:  actual_taken = (op1_i == op2_i);
            3'b001:  actual_taken = (op1_i != op2_i);
            3'b100:  actual_taken = ($signed(op1_i) <  $signed(op2_i));
            3'b101:  actual_taken = ($signed(op1_i) >= $signed(op2_i));
            3'b110:  actual_taken = (op1_i <  op2_i);
            3'b111:  actual_taken = (op1_i >= op2_i);
            default: funct3_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        redirect_d      = 1'b0;
        redirect_addr_d = '0;
        br_resolved     = 1'b0;
        mispred         = 1'b0;
        if (int_assert_i) begin
            redirect_d      = 1'b1;
            redirect_addr_d = int_addr_i;
        end else if (state_q == FLUSH) begin
            if (flush_cnt_q == FW'(1)) begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end else begin
                flush_cnt_d = flush_cnt_q - FW'(1);
            end
        end else if (req_valid_i) begin
            case (inst_i[6:0])
                OP_BRANCH: if (funct3_valid) begin
                    br_resolved = 1'b1;
                    mispred = (actual_taken != pred_taken_i) ||
                              (actual_taken && target != pred_addr_i);
                    redirect_d      = mispred;
                    redirect_addr_d = !mispred ? '0 :
                                      actual_taken ? target : inst_addr_i + ADDR_WIDTH'(4);
                end
                OP_JAL, OP_JALR: begin
                    mispred         = !pred_taken_i || (target != pred_addr_i);
                    redirect_d      = mispred;
                    redirect_addr_d = mispred ? target : '0;
                end
                OP_FENCE: begin
                    redirect_d      = 1'b1;
                    redirect_addr_d = target;
                end
                default: ;
            endcase
        end
        // Any redirect (including an interrupt during FLUSH) restarts the squash window.
        if (redirect_d) begin
            state_d     = FLUSH;
            flush_cnt_d = FW'(FLUSH_CYCLES);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            flush_cnt_q   <= '0;
            jump_flag_o   <= 1'b0;
            jump_addr_o   <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            jump_flag_o <= redirect_d;
            jump_addr_o <= redirect_addr_d;
            if (br_resolved)
                br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
            if (mispred)
                mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

`ifdef BRU_BHT_EN
    logic [1:0]    bht_q [BHT_DEPTH];
    logic [IW-1:0] upd_idx;
    logic [IW-1:0] lookup_idx;

    assign upd_idx        = IW'(inst_addr_i >> 2);
    assign lookup_idx     = IW'(lookup_pc_i >> 2);
    assign lookup_taken_o = bht_q[lookup_idx][1];

    // NOTE: the BHT is a register array (not RAM), so it can and must take the weakly-not-taken reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht_q[i] <= 2'b01;
        end else if (br_resolved) begin
            if (actual_taken && bht_q[upd_idx] != 2'b11)
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            else if (!actual_taken && bht_q[upd_idx] != 2'b00)
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup  = ^lookup_pc_i;
    assign lookup_taken_o = 1'b0;
`endif

endmodule
